dmi_uart_frame_engine: RTL
==========================

Name: dmi_uart_frame_engine

Overview:
- Parametrised byte-stream frame engine between the UART byte FIFO interface and the DTM register file (DTMCS, DMI, IDCODE).
- Hunts for a header byte, decodes a cmd/address byte and a length byte, and assembles or serialises registers of arbitrary width LSB-byte-first.
- Issues register write, read and reset requests.
- Adds over the previous generation: generic register width, zero-padded remainder byte, a read-response path, unknown-command skipping, and an inter-byte timeout.

Parameters:
- HEADER, 8'h01, frame start byte.
- ADDR_W, 5, address field width; cmd field width = 8-ADDR_W.
- DATA_W, 41, register width; NBYTES = ceil(DATA_W/8).
- TIMEOUT, 1000000, max idle cycles between bytes inside a frame; also the read-response wait limit.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- rx_data_i  in  8  received byte
- rx_valid_i  in  1  rx byte available
- rx_ready_o  out  1  engine accepts rx byte; transfer on valid&ready
- tx_data_o  out  8  byte to transmit
- tx_valid_o  out  1  tx byte valid
- tx_ready_i  in  1  UART accepts tx byte; transfer on valid&ready
- reg_addr_o  out  ADDR_W  target register address
- reg_wdata_o  out  DATA_W  write data
- reg_we_o  out  1  one-cycle write strobe
- reg_re_o  out  1  one-cycle read request
- reg_rdata_i  in  DATA_W  read data
- reg_rvalid_i  in  1  read data valid
- reset_req_o  out  1  one-cycle DMI reset request
- frame_err_o  out  1  one-cycle error pulse

Behaviour:
- Reset (rst_i high at clk_i edge): state ST_HEADER; all outputs 0 except rx_ready_o=1; shift registers, counters and timer cleared.
  - Reset mid-frame or mid-transmit aborts immediately; tx_valid_o drops even without a handshake.
- Commands: CMD_READ=0, CMD_WRITE=1, CMD_RESET=2; all other codes are unknown.
- rx_ready_o=1 only in ST_HEADER, ST_CMDADDR, ST_LENGTH and ST_DATA; 0 otherwise, giving backpressure.
- ST_HEADER: bytes other than HEADER are dropped silently. HEADER goes to ST_CMDADDR.
- ST_CMDADDR: latch cmd=byte[7:ADDR_W] and addr=byte[ADDR_W-1:0], then go to ST_LENGTH.
- ST_LENGTH: latch len (0..255) and clear byte count cnt.
  - len=0: WRITE goes to ST_WRITE with wdata=0; READ goes to ST_RREQ; RESET goes to ST_RST; unknown goes to ST_HEADER with frame_err_o pulse.
  - len>0: go to ST_DATA.
- ST_DATA: accept len bytes.
  - WRITE: byte k<NBYTES is placed at wdata[8k+7:8k], truncated to DATA_W; bytes k>=NBYTES are consumed and ignored.
  - Other commands: bytes are consumed and discarded.
  - After the last byte: WRITE goes to ST_WRITE, READ goes to ST_RREQ, RESET goes to ST_RST, unknown goes to ST_HEADER with frame_err_o pulse.
- ST_WRITE: reg_we_o=1 for one cycle with reg_addr_o/reg_wdata_o stable; next state ST_HEADER.
- ST_RST: reset_req_o=1 for one cycle; next state ST_HEADER.
- ST_RREQ: reg_re_o=1 for one cycle, then go to ST_RWAIT.
- ST_RWAIT: capture reg_rdata_i on reg_rvalid_i and go to ST_SEND.
  - reg_rvalid_i in the same cycle as reg_re_o is ignored.
  - TIMEOUT cycles without rvalid: capture all-ones, pulse frame_err_o, go to ST_SEND.
- ST_SEND: emit NBYTES bytes LSB first.
  - Final byte carries the DATA_W%8 remainder bits, upper bits zero; a full byte if DATA_W%8=0.
  - tx_data_o/tx_valid_o are held stable until tx_ready_i.
  - After the last handshake: tx_valid_o=0 and go to ST_HEADER.
- Inter-byte timeout: in ST_CMDADDR, ST_LENGTH and ST_DATA the timer counts cycles with no rx handshake and resets on each handshake. On reaching TIMEOUT: frame_err_o pulse, go to ST_HEADER, discard partial data, no register strobe.
- A HEADER value received inside ST_CMDADDR, ST_LENGTH or ST_DATA is treated as payload, not resync.
- reg_addr_o holds the latched address from ST_CMDADDR until the next frame.

Test Plan:
- Write: rx 01 31 06 EF BE AD DE 34 01 (cmd1, addr 0x11, len 6) -> one reg_we_o pulse, reg_addr_o=0x11, reg_wdata_o=41'h1_34DE_ADBE_EF; the 0x01 byte is truncated to bit 40.
- Read: rx 01 01 00, then reg_rvalid_i with reg_rdata_i=41'h1_0000_0001 two cycles after reg_re_o -> tx bytes 01 00 00 00 00 01. Hold tx_ready_i low 5 cycles before the first byte -> tx_data_o stable throughout.
- Garbage, long write and reset: rx AA 55 01 2F 08 plus 8 bytes (cmd1, addr 0x0F, len 8) -> only bytes 0-5 land in wdata, one we pulse. Then rx 01 40 00 -> one reset_req_o pulse, no we/re.
- Unknown command: rx 01 E0 02 11 22 -> frame_err_o pulse, no strobes. A following valid read frame is serviced normally.
- Timeouts (TIMEOUT=16): rx 01 31 06 AA then stall 16 cycles -> frame_err_o, no we. A read frame with no reg_rvalid_i -> frame_err_o, tx 6 bytes FF FF FF FF FF 01.
- Reset mid-send: assert rst_i after the 2nd tx byte -> next cycle tx_valid_o=0 and rx_ready_o=1. A new write frame then works.

Source files
------------

// File: rtl/dmi_uart_frame_engine.sv
`default_nettype none
// ============================================================================
// Module   : dmi_uart_frame_engine
// Purpose  : Byte-stream frame engine between a UART byte FIFO and the DTM
//            register file (DTMCS, DMI, IDCODE). Hunts for a header byte,
//            decodes a cmd/address byte and a length byte, then assembles a
//            register write (LSB byte first), issues a read and serialises the
//            response (LSB byte first, zero-padded last byte), or issues a
//            DMI reset request. Unknown commands are skipped with an error
//            pulse; an inter-byte timeout aborts stalled frames.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i         in   1       clock
//   rst_i         in   1       synchronous active-high reset
//   rx_data_i     in   8       received byte
//   rx_valid_i    in   1       rx byte available
//   rx_ready_o    out  1       engine accepts rx byte (valid & ready = transfer)
//   tx_data_o     out  8       byte to transmit
//   tx_valid_o    out  1       tx byte valid
//   tx_ready_i    in   1       UART accepts tx byte (valid & ready = transfer)
//   reg_addr_o    out  ADDR_W  target register address
//   reg_wdata_o   out  DATA_W  write data
//   reg_we_o      out  1       one-cycle write strobe
//   reg_re_o      out  1       one-cycle read request
//   reg_rdata_i   in   DATA_W  read data
//   reg_rvalid_i  in   1       read data valid
//   reset_req_o   out  1       one-cycle DMI reset request
//   frame_err_o   out  1       one-cycle error pulse
// ============================================================================
module dmi_uart_frame_engine #(
  parameter logic [7:0] HEADER  = 8'h01,
  parameter int         ADDR_W  = 5,
  parameter int         DATA_W  = 41,
  parameter int         TIMEOUT = 1000000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic              reg_we_o,
  output logic              reg_re_o,
  input  logic [DATA_W-1:0] reg_rdata_i,
  input  logic              reg_rvalid_i,
  output logic              reset_req_o,
  output logic              frame_err_o
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int c_cmd_w  = 8 - ADDR_W;
  localparam int c_nbytes = (DATA_W + 7) / 8;
  localparam int c_txw    = c_nbytes * 8;
  localparam int c_tmr_w  = $clog2(TIMEOUT + 1);
  localparam int c_scnt_w = $clog2(c_nbytes + 1);

  localparam logic [c_cmd_w-1:0] c_cmd_read  = c_cmd_w'(0);
  localparam logic [c_cmd_w-1:0] c_cmd_write = c_cmd_w'(1);
  localparam logic [c_cmd_w-1:0] c_cmd_reset = c_cmd_w'(2);

  localparam logic [c_tmr_w-1:0]  c_tmr_last  = c_tmr_w'(TIMEOUT - 1);
  localparam logic [c_scnt_w-1:0] c_scnt_last = c_scnt_w'(c_nbytes - 1);

  // FSM encoding
  localparam logic [3:0] c_st_header  = 4'd0;
  localparam logic [3:0] c_st_cmdaddr = 4'd1;
  localparam logic [3:0] c_st_length  = 4'd2;
  localparam logic [3:0] c_st_data    = 4'd3;
  localparam logic [3:0] c_st_write   = 4'd4;
  localparam logic [3:0] c_st_rst     = 4'd5;
  localparam logic [3:0] c_st_rreq    = 4'd6;
  localparam logic [3:0] c_st_rwait   = 4'd7;
  localparam logic [3:0] c_st_send    = 4'd8;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [3:0]          r_state;
  logic [c_cmd_w-1:0]  r_cmd;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_len;
  logic [7:0]          r_cnt;
  logic [DATA_W-1:0]   r_wdata;
  logic [c_txw-1:0]    r_txbuf;
  logic [c_scnt_w-1:0] r_scnt;
  logic [c_tmr_w-1:0]  r_timer;
  logic                r_frame_err;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic                w_rx_ready;
  logic                w_rx_fire;
  logic                w_tx_fire;
  logic                w_timer_expired;
  logic [3:0]          w_dispatch_state;
  logic                w_dispatch_err;
  logic [DATA_W-1:0]   w_byte_ext;
  logic [10:0]         w_shamt;
  logic [DATA_W-1:0]   w_wdata_next;

  assign w_rx_ready = (r_state == c_st_header)  || (r_state == c_st_cmdaddr) ||
                      (r_state == c_st_length)  || (r_state == c_st_data);
  assign w_rx_fire       = rx_valid_i && w_rx_ready;
  assign w_tx_fire       = (r_state == c_st_send) && tx_ready_i;
  assign w_timer_expired = (r_timer == c_tmr_last);

  // Byte k lands at bit 8k. Shifting past DATA_W naturally drops both the
  // truncated high bits of the last byte and any surplus bytes k >= NBYTES.
  // Each position is written once per frame into a cleared register, so an
  // OR is sufficient to merge it.
  assign w_byte_ext   = DATA_W'(rx_data_i);
  assign w_shamt      = {r_cnt, 3'b000};
  assign w_wdata_next = r_wdata | (w_byte_ext << w_shamt);

  // Where a frame goes once its header, length and payload are complete.
  always_comb begin
    w_dispatch_state = c_st_header;
    w_dispatch_err   = 1'b0;
    case (r_cmd)
      c_cmd_write: w_dispatch_state = c_st_write;
      c_cmd_read:  w_dispatch_state = c_st_rreq;
      c_cmd_reset: w_dispatch_state = c_st_rst;
      default:     w_dispatch_err   = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // Main FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= c_st_header;
      r_cmd       <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_wdata     <= '0;
      r_txbuf     <= '0;
      r_scnt      <= '0;
      r_timer     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        c_st_header: begin
          r_timer <= '0;
          if (w_rx_fire && (rx_data_i == HEADER)) begin
            r_state <= c_st_cmdaddr;
          end
        end

        // All in-frame receive states share the inter-byte timeout. A HEADER
        // value seen here is plain payload; only the timeout resynchronises.
        c_st_cmdaddr, c_st_length, c_st_data: begin
          if (w_rx_fire) begin
            r_timer <= '0;
            case (r_state)
              c_st_cmdaddr: begin
                r_cmd   <= rx_data_i[7:ADDR_W];
                r_addr  <= rx_data_i[ADDR_W-1:0];
                r_state <= c_st_length;
              end
              c_st_length: begin
                r_len   <= rx_data_i;
                r_cnt   <= '0;
                r_wdata <= '0;
                if (rx_data_i == 8'd0) begin
                  r_state     <= w_dispatch_state;
                  r_frame_err <= w_dispatch_err;
                end else begin
                  r_state <= c_st_data;
                end
              end
              default: begin
                if (r_cmd == c_cmd_write) begin
                  r_wdata <= w_wdata_next;
                end
                r_cnt <= r_cnt + 8'd1;
                if (r_cnt == (r_len - 8'd1)) begin
                  r_state     <= w_dispatch_state;
                  r_frame_err <= w_dispatch_err;
                end
              end
            endcase
          end else if (w_timer_expired) begin
            r_timer     <= '0;
            r_wdata     <= '0;
            r_frame_err <= 1'b1;
            r_state     <= c_st_header;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        c_st_write: r_state <= c_st_header;

        c_st_rst:   r_state <= c_st_header;

        // Any rvalid coinciding with the request cycle is not looked at here,
        // so it is ignored by construction.
        c_st_rreq: begin
          r_timer <= '0;
          r_state <= c_st_rwait;
        end

        c_st_rwait: begin
          if (reg_rvalid_i) begin
            r_txbuf <= c_txw'(reg_rdata_i);
            r_scnt  <= '0;
            r_state <= c_st_send;
          end else if (w_timer_expired) begin
            r_txbuf     <= c_txw'({DATA_W{1'b1}});
            r_scnt      <= '0;
            r_frame_err <= 1'b1;
            r_state     <= c_st_send;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        // The buffer was loaded zero-extended, so the final byte carries the
        // remainder bits with its upper bits cleared.
        c_st_send: begin
          if (w_tx_fire) begin
            r_txbuf <= r_txbuf >> 8;
            r_scnt  <= r_scnt + 1'b1;
            if (r_scnt == c_scnt_last) begin
              r_state <= c_st_header;
            end
          end
        end

        default: r_state <= c_st_header;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign rx_ready_o  = w_rx_ready;
  assign tx_data_o   = r_txbuf[7:0];
  assign tx_valid_o  = (r_state == c_st_send);
  assign reg_addr_o  = r_addr;
  assign reg_wdata_o = r_wdata;
  assign reg_we_o    = (r_state == c_st_write);
  assign reg_re_o    = (r_state == c_st_rreq);
  assign reset_req_o = (r_state == c_st_rst);
  assign frame_err_o = r_frame_err;

endmodule
`default_nettype wire
